// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - req/gnt/rvalid memory port between cache controller and data memory
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_err;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - Word-organised data memory answering the cache memory port in order
module data_mem_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH       = 1024,
  parameter int GNT_DELAY       = 0,
  parameter int RSP_LATENCY     = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WC_W  = $clog2(GNT_DELAY + 1) + 1;
  localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WC_W-1:0]       GNT_DELAY_C = WC_W'(GNT_DELAY);
  localparam logic [OC_W-1:0]       MAX_OUT_C   = OC_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_C     = ADDR_WIDTH'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
  logic [WC_W-1:0]        wait_cnt;
  logic [OC_W-1:0]        outstanding;
  logic [RSP_LATENCY-1:0] pipe_valid;
  logic [RSP_LATENCY-1:0] pipe_err;
  logic [DATA_WIDTH-1:0]  pipe_data [RSP_LATENCY];

  logic [ADDR_WIDTH-3:0] word_addr;
  logic [IDX_W-1:0]      word;
  logic                  in_range;
  logic                  delay_ok;
  logic                  accept;
  logic                  retiring;
  logic                  unused_addr_lsb;

  assign word_addr       = bus.mem_addr[ADDR_WIDTH-1:2];
  assign word            = word_addr[IDX_W-1:0];
  assign in_range        = {2'b00, word_addr} < DEPTH_C;
  assign unused_addr_lsb = ^bus.mem_addr[1:0];

  // wait_cnt saturates at GNT_DELAY, so reaching it is the same as >= GNT_DELAY
  assign delay_ok = (wait_cnt == GNT_DELAY_C);
  assign retiring = pipe_valid[RSP_LATENCY-1];
  assign bus.mem_gnt = bus.mem_req && delay_ok && ((outstanding < MAX_OUT_C) || retiring);
  assign accept      = bus.mem_req && bus.mem_gnt;

  assign bus.mem_rvalid = pipe_valid[RSP_LATENCY-1];
  assign bus.mem_err    = pipe_err[RSP_LATENCY-1];
  assign bus.mem_rdata  = pipe_data[RSP_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      outstanding <= '0;
      pipe_valid  <= '0;
      pipe_err    <= '0;
      for (int i = 0; i < RSP_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      if (!bus.mem_req || accept) begin
        wait_cnt <= '0;
      end else if (wait_cnt != GNT_DELAY_C) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (accept && !retiring && (outstanding != MAX_OUT_C)) begin
        outstanding <= outstanding + 1'b1;
      end else if (!accept && retiring && (outstanding != '0)) begin
        outstanding <= outstanding - 1'b1;
      end

      // Stage 0 samples the array at the acceptance edge; writes and errors return zero data
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept && !in_range;
      pipe_data[0]  <= (accept && !bus.mem_we && in_range) ? mem[word] : '0;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.mem_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_be[i]) begin
          mem[word][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - Directed bench for data_mem_responder across four parameter sets
module tb_data_mem_responder;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req = '0;
  logic [3:0]  we  = '0;
  logic [31:0] addr  [4];
  logic [3:0]  be    [4];
  logic [31:0] wdata [4];
  wire  [3:0]  gnt;
  wire  [3:0]  rvalid;
  wire  [3:0]  err;
  wire  [31:0] rdata [4];

  int tests  = 0;
  int failed = 0;

  data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();
  data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  assign b0.mem_req = req[0]; assign b0.mem_we = we[0]; assign b0.mem_addr = addr[0];
  assign b0.mem_be  = be[0];  assign b0.mem_wdata = wdata[0];
  assign b1.mem_req = req[1]; assign b1.mem_we = we[1]; assign b1.mem_addr = addr[1];
  assign b1.mem_be  = be[1];  assign b1.mem_wdata = wdata[1];
  assign b2.mem_req = req[2]; assign b2.mem_we = we[2]; assign b2.mem_addr = addr[2];
  assign b2.mem_be  = be[2];  assign b2.mem_wdata = wdata[2];
  assign b3.mem_req = req[3]; assign b3.mem_we = we[3]; assign b3.mem_addr = addr[3];
  assign b3.mem_be  = be[3];  assign b3.mem_wdata = wdata[3];

  assign gnt    = {b3.mem_gnt, b2.mem_gnt, b1.mem_gnt, b0.mem_gnt};
  assign rvalid = {b3.mem_rvalid, b2.mem_rvalid, b1.mem_rvalid, b0.mem_rvalid};
  assign err    = {b3.mem_err, b2.mem_err, b1.mem_err, b0.mem_err};
  assign rdata[0] = b0.mem_rdata;
  assign rdata[1] = b1.mem_rdata;
  assign rdata[2] = b2.mem_rdata;
  assign rdata[3] = b3.mem_rdata;

  data_mem_responder u0 (.clk(clk), .reset(reset), .bus(b0));
  data_mem_responder #(.RSP_LATENCY(2)) u1 (.clk(clk), .reset(reset), .bus(b1));
  data_mem_responder #(.GNT_DELAY(3), .MAX_OUTSTANDING(1), .RSP_LATENCY(4)) u2 (.clk(clk), .reset(reset), .bus(b2));
  data_mem_responder #(.RSP_LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3));

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full-word request on unit u with bounded waits; glat = cycles before gnt, rlat = cycles from acceptance to rvalid
  task automatic xact(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int glat, output int rlat);
    req[u] = 1'b1; we[u] = w; addr[u] = a; be[u] = 4'hF; wdata[u] = d;
    glat = 0;
    @(negedge clk);
    while (!gnt[u] && glat < 20) begin
      @(posedge clk); #1; glat++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req[u] = 1'b0;
    rlat = 1;
    @(negedge clk);
    while (!rvalid[u] && rlat < 20) begin
      @(posedge clk); #1; rlat++;
      @(negedge clk);
    end
    rd = rdata[u];
    e  = err[u];
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          gl, rl, cnt;

    for (int i = 0; i < 4; i++) begin
      addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end
    vt[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,       4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h20,       4'hF, 32'hAABBCCDD, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h20,       4'h5, 32'h11223344, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h20,       4'hF, 32'h0,        32'hAA22CC44, 1'b0};
    vt[5]  = '{1'b1, 32'h20,       4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h20,       4'hF, 32'h0,        32'hAA22CC44, 1'b0};
    vt[7]  = '{1'b1, 32'h0,        4'hF, 32'h12345678, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 32'h1000,     4'hF, 32'h0,        32'h0,        1'b1};
    vt[9]  = '{1'b1, 32'h1000,     4'hF, 32'hCAFEF00D, 32'h0,        1'b1};
    vt[10] = '{1'b0, 32'h0,        4'hF, 32'h0,        32'h12345678, 1'b0};
    vt[11] = '{1'b0, 32'h13,       4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[12] = '{1'b1, 32'hFFC,      4'hF, 32'h5A5A5A5A, 32'h0,        1'b0};
    vt[13] = '{1'b0, 32'hFFC,      4'hF, 32'h0,        32'h5A5A5A5A, 1'b0};
    vt[14] = '{1'b0, 32'hFFFFFFF0, 4'hF, 32'h0,        32'h0,        1'b1};

    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Unit 0, default parameters: single requests from the table
    for (int i = 0; i < NV; i++) begin
      req[0] = 1'b1; we[0] = vt[i].w; addr[0] = vt[i].a; be[0] = vt[i].b; wdata[0] = vt[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), 32'(gnt[0]), 32'h1);
      check($sformatf("vec%0d_quiet", i), 32'(rvalid[0]), 32'h0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid[0]), 32'h1);
      check($sformatf("vec%0d_rdata", i), rdata[0], vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(err[0]), 32'(vt[i].exp_err));
      @(posedge clk); #1;
    end

    // Unit 0: read accepted the cycle after a write to the same word
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; be[0] = 4'hF; wdata[0] = 32'h0F0F0F0F;
    @(negedge clk);
    check("raw_wr_gnt", 32'(gnt[0]), 32'h1);
    @(posedge clk); #1;
    we[0] = 1'b0;
    @(negedge clk);
    check("raw_rd_gnt", 32'(gnt[0]), 32'h1);
    check("raw_wr_rvalid", 32'(rvalid[0]), 32'h1);
    check("raw_wr_rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("raw_rd_rvalid", 32'(rvalid[0]), 32'h1);
    check("raw_rd_rdata", rdata[0], 32'h0F0F0F0F);
    @(posedge clk); #1;

    // Unit 1, RSP_LATENCY=2: refill burst of four reads
    for (int i = 0; i < 4; i++) xact(1, 1'b1, 32'h20 + 32'(4*i), 32'hA0A00000 + 32'(i), rd, e, gl, rl);
    check("u1_wr_rlat", 32'(rl), 32'd2);
    for (int i = 0; i < 7; i++) begin
      req[1] = (i < 4); we[1] = 1'b0; addr[1] = 32'h20 + 32'(4*i);
      @(negedge clk);
      check($sformatf("burst%0d_gnt", i), 32'(gnt[1]), 32'(i < 4));
      check($sformatf("burst%0d_rvalid", i), 32'(rvalid[1]), 32'(i >= 2 && i < 6));
      if (i >= 2 && i < 6) check($sformatf("burst%0d_rdata", i), rdata[1], 32'hA0A00000 + 32'(i-2));
      @(posedge clk); #1;
    end
    req[1] = 1'b0;

    // Unit 2, GNT_DELAY=3: dropping req before grant must clear the wait counter
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40; be[2] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("drop%0d_gnt", i), 32'(gnt[2]), 32'h0);
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    @(posedge clk); #1;
    xact(2, 1'b1, 32'h40, 32'h0BADF00D, rd, e, gl, rl);
    check("u2_glat", 32'(gl), 32'd3);
    check("u2_rlat", 32'(rl), 32'd4);
    check("u2_wr_err", 32'(e), 32'h0);

    // Unit 2, MAX_OUTSTANDING=1: second request held off until the first response retires
    for (int i = 0; i < 12; i++) begin
      req[2] = (i < 8); we[2] = (i < 4); addr[2] = 32'h44; be[2] = 4'hF; wdata[2] = 32'h600DCAFE;
      @(negedge clk);
      check($sformatf("stall%0d_gnt", i), 32'(gnt[2]), 32'(i == 3 || i == 7));
      check($sformatf("stall%0d_rvalid", i), 32'(rvalid[2]), 32'(i == 7 || i == 11));
      if (i == 7)  check("stall_wr_rdata", rdata[2], 32'h0);
      if (i == 11) check("stall_rd_rdata", rdata[2], 32'h600DCAFE);
      @(posedge clk); #1;
    end
    req[2] = 1'b0;

    // Unit 3, RSP_LATENCY=3: reset pulsed with two reads in flight
    xact(3, 1'b1, 32'h8, 32'h77778888, rd, e, gl, rl);
    check("u3_wr_rlat", 32'(rl), 32'd3);
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'hC; be[3] = 4'hF; wdata[3] = 32'h13572468;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("infl%0d_gnt", i), 32'(gnt[3]), 32'h1);
      @(posedge clk); #1;
      we[3] = 1'b0; addr[3] = 32'h8;
    end
    req[3] = 1'b0;
    check("pre_rst_rvalid", 32'(rvalid[3]), 32'h1);
    reset = 1'b1;
    #1;
    check("async_rst_rvalid", 32'(rvalid), 32'h0);
    check("async_rst_err", 32'(err), 32'h0);
    check("async_rst_rdata", rdata[3], 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid != 4'h0) cnt++;
      @(posedge clk); #1;
    end
    check("post_rst_rvalid_count", 32'(cnt), 32'h0);
    xact(3, 1'b0, 32'hC, 32'h0, rd, e, gl, rl);
    check("post_rst_glat", 32'(gl), 32'd0);
    check("post_rst_rlat", 32'(rl), 32'd3);
    check("post_rst_wr_kept", rd, 32'h13572468);
    xact(3, 1'b0, 32'h8, 32'h0, rd, e, gl, rl);
    check("post_rst_rd8", rd, 32'h77778888);
    check("post_rst_err", 32'(e), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data-memory responder that sits at the far end of the cache controller's memory port. It answers the req/gnt/rvalid handshake the controller drives on `mem_*`, and applies byte-enabled writes to an internal SRAM array. It returns read data in order with a configurable grant delay and response latency, so the cache refill path (FETCH_1..FETCH_4) can be exercised and later replaced by real memory.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data word width; must be 32 (4 byte lanes).
- `MEM_DEPTH`, 1024: number of words in the array.
- `GNT_DELAY`, 0: cycles `mem_req` must be held before `mem_gnt` can assert (0 = same-cycle grant).
- `RSP_LATENCY`, 1: cycles from acceptance edge to `mem_rvalid`; legal range 1..8.
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unanswered requests; legal range 1..8.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `mem_req` input 1: request from initiator.
- `mem_addr` input ADDR_WIDTH: byte address; bits [1:0] ignored.
- `mem_we` input 1: 1 = write, 0 = read.
- `mem_be` input 4: byte enables for writes.
- `mem_wdata` input DATA_WIDTH: write data.
- `mem_gnt` output 1: request accepted this cycle (combinational from `mem_req`).
- `mem_rvalid` output 1: response valid, one cycle per accepted request.
- `mem_rdata` output DATA_WIDTH: read data; 0 for writes and errors.
- `mem_err` output 1: qualifies `mem_rvalid`; set when the address is out of range.

## Operation
- Acceptance is the cycle in which `mem_req && mem_gnt` are both high. Every accepted request produces exactly one `mem_rvalid` pulse. Responses come back in acceptance order.
- Word index is `mem_addr[ADDR_WIDTH-1:2]`. The index is in range if it is < MEM_DEPTH.
- Grant-delay counter `wait_cnt` (saturating):
  - increments each cycle `mem_req`=1 without acceptance;
  - clears on acceptance or when `mem_req`=0.
- `mem_gnt = mem_req && (wait_cnt >= GNT_DELAY) && (outstanding < MAX_OUTSTANDING || retiring)`. `retiring` means `mem_rvalid` is high this cycle.
- Outstanding counter:
  - +1 on acceptance, −1 on `mem_rvalid`;
  - both in the same cycle leave it unchanged;
  - never exceeds MAX_OUTSTANDING and never underflows.
- Write in range: at the acceptance edge, each byte lane i with `mem_be[i]`=1 is updated from `mem_wdata[8i+7:8i]`. `mem_be`=0 is a legal no-op and is still answered. The response has rdata=0, err=0.
- Read in range: the array is sampled at the acceptance edge and the full word is returned; `mem_be` is ignored.
- Out of range, read or write: the array is not modified. The response has rdata=0 and err=1.
- Response pipeline: RSP_LATENCY-stage shift register of {valid, err, rdata}. The stage-1 entry is loaded at the acceptance edge, and the last stage drives the outputs.
- Array contents are not reset; they are X until written. The array is inferred as one synchronous-write RAM.

## Timing
- Reset values: `mem_gnt`=0 (while `mem_req`=0), `mem_rvalid`=0, `mem_rdata`=0, `mem_err`=0, `wait_cnt`=0, outstanding=0, all pipeline valids 0.
- Reset asserted mid-operation: all in-flight responses are discarded immediately, and no `mem_rvalid` appears after reset releases. A write already accepted before the reset edge remains in the array.
- Grant timing: with GNT_DELAY=N, `mem_gnt` first rises in the (N+1)th consecutive cycle of `mem_req`. With N=0 it rises in the same cycle as `mem_req`.
- Response timing: request accepted at edge k gives `mem_rvalid`=1 during the cycle after edge k+RSP_LATENCY−1. With RSP_LATENCY=1, rvalid is high in the cycle directly after acceptance.
- Read-after-write: a read accepted in the cycle after a write to the same word returns the new data. A read and write cannot be accepted in the same cycle, so there is no same-cycle conflict.
- Back-to-back: with GNT_DELAY=0, one acceptance per cycle is sustained while outstanding < MAX_OUTSTANDING or a response retires that cycle.
- Initiator dropping `mem_req` before grant is legal: nothing is accepted and `wait_cnt` clears.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 (be=1111), then read 0x10, with defaults → gnt in same cycle as req; rvalid one cycle after each acceptance; read rdata=0xDEADBEEF, err=0.
- Byte lanes: write 0xAABBCCDD be=1111, then 0x11223344 be=0101, then read → 0xAA22CC44; write with be=0000 gets rvalid and leaves data unchanged.
- Refill burst, GNT_DELAY=0, RSP_LATENCY=2: reads of 0x20, 0x24, 0x28, 0x2C on consecutive cycles → four rvalids on consecutive cycles, starting 2 cycles after the first acceptance, data in order.
- GNT_DELAY=3, MAX_OUTSTANDING=1, RSP_LATENCY=4: hold req → gnt in 4th cycle; a second req is stalled until the cycle rvalid of the first is high.
- Out of range: read and write at byte address MEM_DEPTH*4 → rvalid with err=1, rdata=0; later read of word 0 is unaffected.
- Reset pulsed while 2 reads are in flight (RSP_LATENCY=3) → all outputs 0 immediately; no rvalid after release; the next request behaves as after a clean reset.
